cry_rgb_expand: RTL

Pixel-path stage wrapped around the CRY colour lookup ROMs (red/green/blue 256×8 tables, one-cycle registered read on `sys_clk`). Accepts 16-bit CRY pixels over a valid/ready handshake and drives the shared 8-bit ROM address from the pixel's colour byte. Holds that address steady across stalls, then scales each ROM output by the pixel's intensity byte. Emits 24-bit RGB over a second valid/ready handshake to the video output stage.

---
 rtl/cry_rgb_expand.sv | 107 ++++++++++
 1 files changed

// File: rtl/cry_rgb_expand.sv
// cry_rgb_expand: CRY-to-RGB pixel stage around the shared colour lookup ROMs.
// S1 waits for the ROM read and holds the intensity byte; S2 scales each ROM
// channel by that intensity and holds the RGB result for the video output.
module cry_rgb_expand (
  input  logic        sys_clk,
  input  logic        resetl,
  input  logic [15:0] pix_in,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [7:0]  rom_addr,
  input  logic [7:0]  rom_r,
  input  logic [7:0]  rom_g,
  input  logic [7:0]  rom_b,
  output logic [23:0] rgb_out,
  output logic        rgb_valid,
  input  logic        rgb_ready
);

  // Round-to-nearest of c*y/255 using only a multiply, adds and shifts.
  // Sums stay below 2^16 (255*255 + 128 + 254), so 16 bits are enough.
  function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] y);
    logic [15:0] p;
    logic [15:0] s;
    p = ({8'd0, c} * {8'd0, y}) + 16'd128;
    s = p + {8'd0, p[15:8]};
    return 8'(s >> 8);
  endfunction

  logic        s1_v_q, s1_v_d;
  logic        s2_v_q, s2_v_d;
  logic [7:0]  y1_q, y1_d;
  logic [7:0]  addr_hold_q, addr_hold_d;
  logic [23:0] rgb_q, rgb_d;

  logic        accept_s;
  logic        s2_adv_s;
  logic        s1_adv_s;
  logic        pix_ready_s;

  // Handshake decode: a slot frees up when its contents move on this cycle.
  always_comb begin
    s2_adv_s    = ~s2_v_q | rgb_ready;
    s1_adv_s    = s1_v_q & s2_adv_s;
    pix_ready_s = ~s1_v_q | s2_adv_s;
    accept_s    = pix_valid & pix_ready_s;
  end

  // ROM address: the new colour on accept, otherwise the held one so the
  // ROM keeps returning data for the pixel sitting in S1 during a stall.
  always_comb begin
    if (accept_s) begin
      rom_addr = pix_in[15:8];
    end else begin
      rom_addr = addr_hold_q;
    end
  end

  // Next-state for both pipeline stages.
  always_comb begin
    s1_v_d      = s1_v_q;
    y1_d        = y1_q;
    addr_hold_d = addr_hold_q;
    s2_v_d      = s2_v_q;
    rgb_d       = rgb_q;

    if (accept_s) begin
      s1_v_d      = 1'b1;
      y1_d        = pix_in[7:0];
      addr_hold_d = pix_in[15:8];
    end else if (s1_adv_s) begin
      s1_v_d = 1'b0;
    end else begin
      s1_v_d = s1_v_q;
    end

    if (s1_adv_s) begin
      s2_v_d = 1'b1;
      rgb_d  = {scale_chan(rom_r, y1_q), scale_chan(rom_g, y1_q), scale_chan(rom_b, y1_q)};
    end else if (rgb_ready) begin
      s2_v_d = 1'b0;
    end else begin
      s2_v_d = s2_v_q;
    end
  end

  // Pipeline state registers with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      s1_v_q      <= 1'b0;
      s2_v_q      <= 1'b0;
      y1_q        <= 8'd0;
      addr_hold_q <= 8'd0;
      rgb_q       <= 24'd0;
    end else begin
      s1_v_q      <= s1_v_d;
      s2_v_q      <= s2_v_d;
      y1_q        <= y1_d;
      addr_hold_q <= addr_hold_d;
      rgb_q       <= rgb_d;
    end
  end

  assign pix_ready = pix_ready_s;
  assign rgb_valid = s2_v_q;
  assign rgb_out   = rgb_q;

endmodule
